// File: rtl/bram_porta_arbiter.sv
// Port-A arbiter for the text BRAM: single-word requester vs whole-memory clear engine; read data 1 cycle after accept.
// Backpressure: req_ready_o drops on clr_start_i and on engine turns of a contended clear. BRAM_ARB_CLR_ABORT_EN adds clear abort.
module bram_porta_arbiter #(
    parameter int  DATA_WIDTH  = 8,
    parameter int  DEPTH_WORDS = 2400,
    localparam int ADDR_WIDTH  = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    input  logic                  clr_start_i,
    input  logic [DATA_WIDTH-1:0] clr_data_i,
    output logic                  clr_busy_o,
    output logic                  clr_done_o,
`ifdef BRAM_ARB_CLR_ABORT_EN
    input  logic                  clr_abort_i,
    output logic                  clr_aborted_o,
`endif
    output logic [ADDR_WIDTH-1:0] bram_addra_o,
    output logic                  bram_wea_o,
    output logic [DATA_WIDTH-1:0] bram_dina_o,
    input  logic [DATA_WIDTH-1:0] bram_douta_i
);

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    localparam logic TURN_REQ = 1'b0;
    localparam logic TURN_ENG = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH_WORDS - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   fill_q, fill_d;
    logic                    turn_q, turn_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    done_q, done_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    eng_gnt;
    logic                    req_gnt;
    logic                    clr_abort;

`ifdef BRAM_ARB_CLR_ABORT_EN
    logic                    aborted_q, aborted_d;
    assign clr_abort     = clr_abort_i;
    assign clr_aborted_o = aborted_q;
`else
    assign clr_abort = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fill_q      <= '0;
            turn_q      <= TURN_REQ;
            rsp_valid_q <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
`ifdef BRAM_ARB_CLR_ABORT_EN
            aborted_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            turn_q      <= turn_d;
            rsp_valid_q <= rsp_valid_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
`ifdef BRAM_ARB_CLR_ABORT_EN
            aborted_q   <= aborted_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        turn_d      = turn_q;
        done_d      = 1'b0;
        rsp_valid_d = req_gnt && !req_we_i;
        addr_d      = (eng_gnt || req_gnt) ? bram_addra_o : addr_q;
`ifdef BRAM_ARB_CLR_ABORT_EN
        aborted_d   = aborted_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (clr_start_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    fill_d  = clr_data_i;
                    turn_d  = TURN_ENG;
`ifdef BRAM_ARB_CLR_ABORT_EN
                    aborted_d = 1'b0;
`endif
                end
            end
            ST_CLEAR: begin
                if (clr_abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
`ifdef BRAM_ARB_CLR_ABORT_EN
                    aborted_d = 1'b1;
`endif
                end else begin
                    if (req_valid_i) begin
                        turn_d = ~turn_q;
                    end
                    if (eng_gnt) begin
                        if (cnt_q == LAST_ADDR) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grants are suppressed while rst_i is high so a reset mid-clear leaves the current word untouched.
    always_comb begin
        eng_gnt      = 1'b0;
        req_ready_o  = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ST_IDLE:  req_ready_o = !clr_start_i;
                ST_CLEAR: begin
                    if (!clr_abort) begin
                        req_ready_o = req_valid_i && (turn_q == TURN_REQ);
                        eng_gnt     = !req_valid_i || (turn_q == TURN_ENG);
                    end
                end
                default: req_ready_o = 1'b0;
            endcase
        end
        req_gnt = req_valid_i && req_ready_o;

        bram_addra_o = addr_q;
        bram_wea_o   = 1'b0;
        bram_dina_o  = req_wdata_i;
        if (eng_gnt) begin
            bram_addra_o = cnt_q;
            bram_wea_o   = 1'b1;
            bram_dina_o  = fill_q;
        end else if (req_gnt) begin
            bram_addra_o = req_addr_i;
            bram_wea_o   = req_we_i;
            bram_dina_o  = req_wdata_i;
        end

        clr_busy_o  = (state_q == ST_CLEAR);
        clr_done_o  = done_q;
        rsp_valid_o = rsp_valid_q;
        rsp_rdata_o = rsp_valid_q ? bram_douta_i : '0;
    end

endmodule

// File: tb/tb_bram_porta_arbiter.sv
// Bench for bram_porta_arbiter: a BRAM model on port A, a transaction-level reference model and a response scoreboard.
module tb_bram_porta_arbiter;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          clr_start;
    logic [DW-1:0] clr_data;
    logic          clr_busy, clr_done;
`ifdef BRAM_ARB_CLR_ABORT_EN
    logic          clr_abort, clr_aborted;
`endif
    logic [AW-1:0] bram_addra;
    logic          bram_wea;
    logic [DW-1:0] bram_dina, bram_douta;

    always #5 clk = ~clk;

    bram_porta_arbiter #(.DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .clr_start_i(clr_start), .clr_data_i(clr_data),
        .clr_busy_o(clr_busy), .clr_done_o(clr_done),
`ifdef BRAM_ARB_CLR_ABORT_EN
        .clr_abort_i(clr_abort), .clr_aborted_o(clr_aborted),
`endif
        .bram_addra_o(bram_addra), .bram_wea_o(bram_wea), .bram_dina_o(bram_dina),
        .bram_douta_i(bram_douta)
    );

    // Read-first synchronous BRAM port
    logic [DW-1:0] bram [0:DEPTH-1];
    always @(posedge clk) begin
        bram_douta <= bram[bram_addra];
        if (bram_wea) bram[bram_addra] <= bram_dina;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: screen memory contents, clear progress and whose turn it is.
    bit            armed = 1'b0;
    bit            m_clear, m_eng_turn, m_rsp, m_done, m_abt, m_last_known;
    logic [AW-1:0] m_ptr, m_last;
    logic [DW-1:0] m_fill;
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic [DW-1:0] exp_q [$];
    bit            e_eng, e_usr, e_ready, abort_now;

    always @(negedge clk) if (armed) begin
        abort_now = 1'b0;
`ifdef BRAM_ARB_CLR_ABORT_EN
        abort_now = m_clear && clr_abort;
        check("clr_aborted", clr_aborted, m_abt);
`endif
        e_eng = 1'b0; e_ready = 1'b0;
        if (!rst) begin
            if (!m_clear) e_ready = !clr_start;
            else if (!abort_now) begin
                if (req_valid && !m_eng_turn) e_ready = 1'b1;
                else e_eng = 1'b1;
            end
        end
        e_usr = e_ready && req_valid;

        check("req_ready", req_ready, e_ready);
        check("clr_busy", clr_busy, m_clear);
        check("clr_done", clr_done, m_done);
        check("rsp_valid", rsp_valid, m_rsp);
        if (e_eng) begin
            check("eng_wea", bram_wea, 1);
            check("eng_addr", bram_addra, m_ptr);
            check("eng_din", bram_dina, m_fill);
        end else if (e_usr) begin
            check("req_wea", bram_wea, req_we);
            check("req_addr", bram_addra, req_addr);
            if (req_we) check("req_din", bram_dina, req_wdata);
        end else begin
            check("idle_wea", bram_wea, 0);
            if (m_last_known) check("idle_addr_hold", bram_addra, m_last);
        end

        if (e_usr && !req_we) exp_q.push_back(ref_mem[req_addr]);
        if (e_usr && req_we)  ref_mem[req_addr] = req_wdata;
        if (e_eng)            ref_mem[m_ptr] = m_fill;
        if (e_eng)      begin m_last = m_ptr;    m_last_known = 1'b1; end
        else if (e_usr) begin m_last = req_addr; m_last_known = 1'b1; end
        m_rsp  = e_usr && !req_we;
        m_done = 1'b0;

        if (rst) begin
            m_clear = 0; m_ptr = 0; m_fill = 0; m_eng_turn = 0; m_rsp = 0; m_abt = 0;
            m_last_known = 0;
        end else if (!m_clear) begin
            if (clr_start) begin
                m_clear = 1; m_ptr = 0; m_fill = clr_data; m_eng_turn = 1; m_abt = 0;
            end
        end else if (abort_now) begin
            m_clear = 0; m_ptr = 0; m_abt = 1;
        end else begin
            if (req_valid) m_eng_turn = !m_eng_turn;
            if (e_eng) begin
                if (m_ptr == AW'(DEPTH - 1)) begin m_clear = 0; m_ptr = 0; m_done = 1; end
                else m_ptr = m_ptr + 1'b1;
            end
        end
    end

    // Response monitor
    always @(negedge clk) if (armed) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
            else check("rsp_rdata", rsp_rdata, exp_q.pop_front());
        end else begin
            check("rsp_rdata_zero", rsp_rdata, 0);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit start, input logic [DW-1:0] fill);
        bit hs;
        hs = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        clr_start = start; clr_data = fill;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            hs = req_ready;
            tick();
            clr_start = 1'b0;
            if (hs) break;
        end
        if (!hs) check("req_handshake", hs, 1);
        req_valid = 1'b0;
    endtask

    task automatic clr_pulse(input logic [DW-1:0] fill);
        clr_start = 1'b1; clr_data = fill;
        tick();
        clr_start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 500; n++) begin
            if (!clr_busy) break;
            tick();
        end
        check("clear_finished", clr_busy, 0);
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) do_req(1'b0, AW'(a), 8'h00, 1'b0, 8'h00);
    endtask

    int r;
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            bram[i]    = 8'(i * 13 + 7);
            ref_mem[i] = 8'(i * 13 + 7);
        end
        rst = 1'b1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        clr_start = 0; clr_data = 0;
`ifdef BRAM_ARB_CLR_ABORT_EN
        clr_abort = 0;
`endif
        tick();
        armed = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // single write then read-back
        do_req(1'b1, 4'd3, 8'hA5, 1'b0, 8'h00);
        do_req(1'b0, 4'd3, 8'h00, 1'b0, 8'h00);
        repeat (2) tick();

        // uncontended clear, then verify every word
        clr_pulse(8'h20);
        wait_idle();
        read_all();

        // contended clear with continuous reads of the last word
        do_req(1'b1, 4'd15, 8'h77, 1'b0, 8'h00);
        clr_pulse(8'h55);
        for (int n = 0; n < 100 && clr_busy; n++) do_req(1'b0, 4'd15, 8'h00, 1'b0, 8'h00);
        wait_idle();

        // start and request in the same idle cycle
        do_req(1'b0, 4'd9, 8'h00, 1'b1, 8'h66);
        wait_idle();

        // reset at counter 7
        clr_pulse(8'h99);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        read_all();

`ifdef BRAM_ARB_CLR_ABORT_EN
        clr_pulse(8'h11);
        repeat (5) tick();
        clr_abort = 1'b1;
        tick();
        clr_abort = 1'b0;
        repeat (3) tick();
        clr_pulse(8'h12);
        wait_idle();
        read_all();
`endif

        // randomized mix
        repeat (400) begin
            r = $urandom_range(0, 9);
            if (r < 6)
                do_req(1'($urandom), AW'($urandom), DW'($urandom), ($urandom_range(0, 19) == 0), DW'($urandom));
            else if (r == 6)
                clr_pulse(DW'($urandom));
`ifdef BRAM_ARB_CLR_ABORT_EN
            else if (r == 7 && $urandom_range(0, 3) == 0) begin
                clr_abort = 1'b1; tick(); clr_abort = 1'b0;
            end
`endif
            else
                tick();
        end
        wait_idle();
        read_all();

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
